lsu_arbiter: RTL and testbench

//   Shares the single-ported lsu between two requesters: port 0 (pipeline MEM stage) and

---
 rtl/lsu_arbiter.sv | 122 ++++++++++++
 tb/tb_lsu_arbiter.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : lsu_arbiter
//  Purpose  : Two-port arbiter in front of the single-ported lsu. Port 0 has
//             fixed priority and port 1 has a starvation override. Load data
//             is registered and returned one cycle after acceptance.
//  Revision : 1.0  initial release
// ============================================================================
module lsu_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        i_clk,
    input  logic        i_reset,

    input  logic        i_p0_req,
    input  logic [31:0] i_p0_addr,
    input  logic [31:0] i_p0_wdata,
    input  logic [3:0]  i_p0_bmask,
    input  logic        i_p0_wren,
    output logic        o_p0_gnt,
    output logic        o_p0_rvalid,
    output logic [31:0] o_p0_rdata,

    input  logic        i_p1_req,
    input  logic [31:0] i_p1_addr,
    input  logic [31:0] i_p1_wdata,
    input  logic [3:0]  i_p1_bmask,
    input  logic        i_p1_wren,
    output logic        o_p1_gnt,
    output logic        o_p1_rvalid,
    output logic [31:0] o_p1_rdata,

    output logic [31:0] o_lsu_addr,
    output logic [31:0] o_lsu_wdata,
    output logic [3:0]  o_lsu_bmask,
    output logic        o_lsu_wren,
    input  logic [31:0] i_lsu_rdata
);

    localparam int unsigned      CNT_W   = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] C_LIMIT = CNT_W'(STARVE_LIMIT);

    logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;
    logic             p0_rvalid_q,  p0_rvalid_d;
    logic             p1_rvalid_q,  p1_rvalid_d;
    logic [31:0]      p0_rdata_q,   p0_rdata_d;
    logic [31:0]      p1_rdata_q,   p1_rdata_d;

    logic w_force1;
    logic w_gnt0;
    logic w_gnt1;

    // Grants are masked while reset is held so nothing reaches the lsu bus.
    always_comb begin
        w_force1 = i_p1_req && (starve_cnt_q == C_LIMIT);
        w_gnt1   = i_reset && i_p1_req && (w_force1 || !i_p0_req);
        w_gnt0   = i_reset && i_p0_req && !w_gnt1;
    end

    assign o_p0_gnt = w_gnt0;
    assign o_p1_gnt = w_gnt1;

    always_comb begin
        o_lsu_addr  = 32'd0;
        o_lsu_wdata = 32'd0;
        o_lsu_bmask = 4'd0;
        o_lsu_wren  = 1'b0;
        if (w_gnt0) begin
            o_lsu_addr  = i_p0_addr;
            o_lsu_wdata = i_p0_wdata;
            o_lsu_bmask = i_p0_bmask;
            o_lsu_wren  = i_p0_wren;
        end else if (w_gnt1) begin
            o_lsu_addr  = i_p1_addr;
            o_lsu_wdata = i_p1_wdata;
            o_lsu_bmask = i_p1_bmask;
            o_lsu_wren  = i_p1_wren;
        end
    end

    // Counter restarts whenever port 1 is served or withdraws its request.
    always_comb begin
        starve_cnt_d = '0;
        if (i_p1_req && !w_gnt1) begin
            if (starve_cnt_q == C_LIMIT) begin
                starve_cnt_d = starve_cnt_q;
            end else begin
                starve_cnt_d = starve_cnt_q + CNT_W'(1);
            end
        end
    end

    always_comb begin
        p0_rvalid_d = w_gnt0 && !i_p0_wren;
        p1_rvalid_d = w_gnt1 && !i_p1_wren;
        p0_rdata_d  = p0_rvalid_d ? i_lsu_rdata : p0_rdata_q;
        p1_rdata_d  = p1_rvalid_d ? i_lsu_rdata : p1_rdata_q;
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            starve_cnt_q <= '0;
            p0_rvalid_q  <= 1'b0;
            p1_rvalid_q  <= 1'b0;
            p0_rdata_q   <= 32'd0;
            p1_rdata_q   <= 32'd0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
            p0_rvalid_q  <= p0_rvalid_d;
            p1_rvalid_q  <= p1_rvalid_d;
            p0_rdata_q   <= p0_rdata_d;
            p1_rdata_q   <= p1_rdata_d;
        end
    end

    assign o_p0_rvalid = p0_rvalid_q;
    assign o_p1_rvalid = p1_rvalid_q;
    assign o_p0_rdata  = p0_rdata_q;
    assign o_p1_rdata  = p1_rdata_q;

endmodule
`default_nettype wire

// File: tb/tb_lsu_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_lsu_arbiter
//  Purpose  : Directed bench for lsu_arbiter with a small lsu memory and a
//             cycle-level reference of the arbitration and response rules.
//  Revision : 1.0  initial release
// ============================================================================
module tb_lsu_arbiter;

    localparam int LIMIT = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        p0_req, p0_wren, p1_req, p1_wren;
    logic [31:0] p0_addr, p0_wdata, p1_addr, p1_wdata;
    logic [3:0]  p0_bmask, p1_bmask;
    logic        p0_gnt, p1_gnt, p0_rvalid, p1_rvalid;
    logic [31:0] p0_rdata, p1_rdata;
    logic [31:0] lsu_addr, lsu_wdata, lsu_rdata;
    logic [3:0]  lsu_bmask;
    logic        lsu_wren;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] mem [0:63];

    always #5 clk = ~clk;

    lsu_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .i_clk(clk), .i_reset(rst),
        .i_p0_req(p0_req), .i_p0_addr(p0_addr), .i_p0_wdata(p0_wdata),
        .i_p0_bmask(p0_bmask), .i_p0_wren(p0_wren),
        .o_p0_gnt(p0_gnt), .o_p0_rvalid(p0_rvalid), .o_p0_rdata(p0_rdata),
        .i_p1_req(p1_req), .i_p1_addr(p1_addr), .i_p1_wdata(p1_wdata),
        .i_p1_bmask(p1_bmask), .i_p1_wren(p1_wren),
        .o_p1_gnt(p1_gnt), .o_p1_rvalid(p1_rvalid), .o_p1_rdata(p1_rdata),
        .o_lsu_addr(lsu_addr), .o_lsu_wdata(lsu_wdata), .o_lsu_bmask(lsu_bmask),
        .o_lsu_wren(lsu_wren), .i_lsu_rdata(lsu_rdata)
    );

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        return (a < 32'd256) ? mem[a[7:2]] : 32'd0;
    endfunction

    assign lsu_rdata = (lsu_addr < 32'd256) ? mem[lsu_addr[7:2]] : 32'd0;

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        chk32(name, {31'd0, act}, {31'd0, exp});
    endtask

    // lsu store port; a write seen while reset is low is itself an error
    always @(posedge clk) begin
        if (!rst) begin
            chk1("no_write_in_reset", lsu_wren, 1'b0);
        end else if (lsu_wren && lsu_addr < 32'd256) begin
            mem[lsu_addr[7:2]] = lsu_wdata;
        end
    end

    // Reference: denied = consecutive cycles port 1 has been refused.
    int          denied = 0;
    logic        m_rv0 = 1'b0, m_rv1 = 1'b0;
    logic [31:0] m_rd0 = 32'd0, m_rd1 = 32'd0;

    always @(negedge clk) begin
        logic        e0, e1;
        logic [31:0] ea, ed;
        logic [3:0]  eb;
        logic        ew;
        if (!rst) begin
            e0 = 1'b0; e1 = 1'b0;
            denied = 0;
            m_rv0 = 1'b0; m_rv1 = 1'b0; m_rd0 = 32'd0; m_rd1 = 32'd0;
        end else begin
            e1 = p1_req && (denied >= LIMIT || !p0_req);
            e0 = p0_req && !e1;
        end
        ea = 32'd0; ed = 32'd0; eb = 4'd0; ew = 1'b0;
        if (e0) begin
            ea = p0_addr; ed = p0_wdata; eb = p0_bmask; ew = p0_wren;
        end else if (e1) begin
            ea = p1_addr; ed = p1_wdata; eb = p1_bmask; ew = p1_wren;
        end
        chk1 ("p0_gnt",    p0_gnt,    e0);
        chk1 ("p1_gnt",    p1_gnt,    e1);
        chk32("lsu_addr",  lsu_addr,  ea);
        chk32("lsu_wdata", lsu_wdata, ed);
        chk32("lsu_bmask", {28'd0, lsu_bmask}, {28'd0, eb});
        chk1 ("lsu_wren",  lsu_wren,  ew);
        chk1 ("p0_rvalid", p0_rvalid, m_rv0);
        chk1 ("p1_rvalid", p1_rvalid, m_rv1);
        chk32("p0_rdata",  p0_rdata,  m_rd0);
        chk32("p1_rdata",  p1_rdata,  m_rd1);
        if (rst) begin
            m_rv0 = e0 && !p0_wren;
            m_rv1 = e1 && !p1_wren;
            if (m_rv0) m_rd0 = mem_rd(p0_addr);
            if (m_rv1) m_rd1 = mem_rd(p1_addr);
            if (p1_req && !e1) denied = (denied < LIMIT) ? denied + 1 : denied;
            else               denied = 0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drv0(input logic req, input logic [31:0] a, input logic [31:0] d, input logic wr);
        p0_req = req; p0_addr = a; p0_wdata = d; p0_wren = wr; p0_bmask = 4'b1111;
    endtask

    task automatic drv1(input logic req, input logic [31:0] a, input logic [31:0] d, input logic wr);
        p1_req = req; p1_addr = a; p1_wdata = d; p1_wren = wr; p1_bmask = 4'b1111;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        for (int i = 0; i < 64; i++) mem[i] = 32'd0;
        mem[4] = 32'hDEAD_BEEF;
        rst = 1'b0;

        // Reset held with both ports requesting stores
        drv0(1'b1, 32'h40, 32'hAAAA_0000, 1'b1);
        drv1(1'b1, 32'h44, 32'hBBBB_0000, 1'b1);
        repeat (3) tick();
        #1;
        chk1("rst_p0_gnt", p0_gnt, 1'b0);
        chk1("rst_p1_gnt", p1_gnt, 1'b0);
        chk1("rst_wren", lsu_wren, 1'b0);
        chk1("rst_rvalid", p0_rvalid, 1'b0);
        tick();
        rst = 1'b1;
        #1;
        chk1("release_p0_gnt", p0_gnt, 1'b1);
        chk1("release_p1_gnt", p1_gnt, 1'b0);
        tick();
        drv0(1'b0, 32'h0, 32'h0, 1'b0);
        drv1(1'b0, 32'h0, 32'h0, 1'b0);
        tick();

        // Single port-1 load
        drv1(1'b1, 32'h10, 32'h0, 1'b0);
        #1;
        chk1("p1_load_gnt", p1_gnt, 1'b1);
        tick();
        drv1(1'b0, 32'h0, 32'h0, 1'b0);
        chk1("p1_load_rvalid", p1_rvalid, 1'b1);
        chk32("p1_load_rdata", p1_rdata, 32'hDEAD_BEEF);
        chk1("p1_load_p0_quiet", p0_rvalid, 1'b0);
        tick();

        // Both ports continuously requesting loads
        drv0(1'b1, 32'h40, 32'h0, 1'b0);
        drv1(1'b1, 32'h10, 32'h0, 1'b0);
        for (int i = 0; i < 15; i++) begin
            #1;
            chk1($sformatf("starve_p1_gnt_%0d", i), p1_gnt, (i % 5) == 4);
            tick();
        end
        drv0(1'b0, 32'h0, 32'h0, 1'b0);
        drv1(1'b0, 32'h0, 32'h0, 1'b0);
        tick();
        tick();

        // Store then load to the same word on consecutive cycles
        drv0(1'b1, 32'h20, 32'h1234_5678, 1'b1);
        tick();
        drv0(1'b1, 32'h20, 32'h0, 1'b0);
        chk1("b2b_store_no_rvalid", p0_rvalid, 1'b0);
        tick();
        drv0(1'b0, 32'h0, 32'h0, 1'b0);
        chk1("b2b_load_rvalid", p0_rvalid, 1'b1);
        chk32("b2b_load_rdata", p0_rdata, 32'h1234_5678);
        tick();
        chk1("b2b_rvalid_pulse", p0_rvalid, 1'b0);
        chk32("b2b_rdata_hold", p0_rdata, 32'h1234_5678);

        // Port 1 withdraws after two denied cycles, then re-requests
        drv0(1'b1, 32'h10, 32'h0, 1'b0);
        drv1(1'b1, 32'h44, 32'h0, 1'b0);
        tick();
        tick();
        drv1(1'b0, 32'h0, 32'h0, 1'b0);
        tick();
        drv1(1'b1, 32'h44, 32'h0, 1'b0);
        w = 0;
        while (w < 10) begin
            #1;
            if (p1_gnt) break;
            w++;
            tick();
        end
        chk32("withdraw_wait", w, 32'd4);
        tick();
        drv0(1'b0, 32'h0, 32'h0, 1'b0);
        drv1(1'b0, 32'h0, 32'h0, 1'b0);
        tick();

        // Reset asserted the cycle after an accepted load
        drv0(1'b1, 32'h10, 32'h0, 1'b0);
        tick();
        drv0(1'b0, 32'h0, 32'h0, 1'b0);
        chk1("pre_reset_rvalid", p0_rvalid, 1'b1);
        chk32("pre_reset_rdata", p0_rdata, 32'hDEAD_BEEF);
        #1;
        rst = 1'b0;
        #1;
        chk1("async_rvalid", p0_rvalid, 1'b0);
        chk32("async_rdata", p0_rdata, 32'h0);
        chk32("async_p1_rdata", p1_rdata, 32'h0);
        drv0(1'b1, 32'h10, 32'h0000_0BAD, 1'b1);
        drv1(1'b1, 32'h10, 32'h0000_0BAD, 1'b1);
        repeat (2) tick();
        drv0(1'b0, 32'h0, 32'h0, 1'b0);
        drv1(1'b0, 32'h0, 32'h0, 1'b0);
        rst = 1'b1;
        tick();
        drv1(1'b1, 32'h10, 32'h0, 1'b0);
        tick();
        drv1(1'b0, 32'h0, 32'h0, 1'b0);
        chk32("post_reset_mem_intact", p1_rdata, 32'hDEAD_BEEF);
        repeat (3) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
